// File: rtl/ahb_rr_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite slave between NREQ valid/ready requesters.
// Two-stage (address/data) pipeline gives one transfer per cycle with zero wait states.
module ahb_rr_master_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic [AW-1:0]        HADDR,
    output logic                 HWRITE,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HSIZE,
    output logic [DW-1:0]        HWDATA,
    input  logic [DW-1:0]        HRDATA,
    input  logic                 HREADY
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            a_valid_q, a_write_q;
    logic [IDW-1:0]  a_id_q;
    logic [AW-1:0]   a_addr_q;
    logic [DW-1:0]   a_wdata_q;
    logic            d_valid_q, d_write_q;
    logic [IDW-1:0]  d_id_q;
    logic [DW-1:0]   d_wdata_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;

    logic            found;
    logic [IDW-1:0]  grant_id;
    logic [IDW:0]    scan;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_write;

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        found     = 1'b0;
        grant_id  = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = scan[IDW-1:0];
            end
        end
        grant     = found ? (NREQ'(1) << grant_id) : '0;
        sel_addr  = req_addr[grant_id*AW +: AW];
        sel_wdata = req_wdata[grant_id*DW +: DW];
        sel_write = req_write[grant_id];
        ptr_d     = ptr_q;
        if (HREADY && found) begin
            ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign req_ready = HREADY ? grant : '0;

    // NOTE: state uses <= so every register samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ptr_q       <= '0;
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_id_q      <= '0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_id_q      <= '0;
            d_wdata_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else if (HREADY) begin
            ptr_q     <= ptr_d;
            d_valid_q <= a_valid_q;
            d_write_q <= a_write_q;
            d_id_q    <= a_id_q;
            d_wdata_q <= a_wdata_q;
            a_valid_q <= found;
            if (found) begin
                a_id_q    <= grant_id;
                a_addr_q  <= sel_addr;
                a_write_q <= sel_write;
                a_wdata_q <= sel_wdata;
            end
            rsp_valid_q <= d_valid_q ? (NREQ'(1) << d_id_q) : '0;
            if (d_valid_q && !d_write_q) begin
                rsp_rdata_q <= HRDATA;
            end
        end else begin
            // A wait state stalls both stages; the completion pulse lasts one cycle.
            rsp_valid_q <= '0;
        end
    end

    assign HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = {a_addr_q[AW-1:2], 2'b00};
    assign HWRITE    = a_write_q;
    assign HSIZE     = 3'b010;
    assign HWDATA    = d_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_rr_master_arbiter.sv
// Bench for ahb_rr_master_arbiter: AHB word-memory slave model, response scoreboard,
// a grant vector table and hand-written latency / wait-state / reset sequences.
module tb_ahb_rr_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    always #5 HCLK = ~HCLK;

    ahb_rr_master_arbiter #(.NREQ(2), .AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    // Slave model: 64-word memory, AHB-Lite address/data phase tracking.
    logic [31:0] mem [64];
    logic        dp_valid, dp_write;
    logic [5:0]  dp_idx;
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
        end else begin
            if (pre_we) mem[pre_idx] <= pre_data;
            if (HREADY) begin
                if (dp_valid && dp_write) mem[dp_idx] <= HWDATA;
                dp_valid <= HTRANS[1];
                dp_write <= HWRITE;
                dp_idx   <= HADDR[7:2];
            end
        end
    end
    assign HRDATA = (dp_valid && !dp_write) ? mem[dp_idx] : 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected completions queued at handshake, popped on rsp_valid.
    typedef struct {
        int          id;
        logic        write;
        logic [31:0] rdata;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem [64];

    always @(negedge HCLK) begin
        exp_t e;
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_rsp_valid", {30'd0, rsp_valid}, 32'd1 << e.id);
                if (!e.write) check("sb_rsp_rdata", rsp_rdata, e.rdata);
            end
        end
        if (HRESET) begin
            sb.delete();
        end else begin
            if (pre_we) ref_mem[pre_idx] = pre_data;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id    = i;
                    e.write = req_write[i];
                    e.rdata = ref_mem[req_addr[i*32+2 +: 6]];
                    if (req_write[i]) ref_mem[req_addr[i*32+2 +: 6]] = req_wdata[i*32 +: 32];
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic w,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_valid[id]          = v;
        req_write[id]          = w;
        req_addr[id*32 +: 32]  = addr;
        req_wdata[id*32 +: 32] = wd;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic do_req(input int id, input logic w, input logic [31:0] addr, input logic [31:0] wd);
        bit done = 1'b0;
        set_req(id, 1'b1, w, addr, wd);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge HCLK);
            if (req_ready[id]) done = 1'b1;
        end
        check("handshake_seen", {31'd0, done}, 32'd1);
        @(posedge HCLK); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = 6'(idx);
        pre_data = data;
        @(posedge HCLK); #1;
        pre_we   = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    task automatic drain();
        repeat (5) @(posedge HCLK);
        #1;
    endtask

    typedef struct {
        logic [1:0] valid;
        logic       hready;
        logic [1:0] exp_ready;
    } vec_t;
    vec_t vecs[15];

    logic [31:0] s_haddr, s_hwdata;
    logic [1:0]  s_htrans;

    initial begin
        vecs[0]  = '{2'b11, 1'b1, 2'b01};
        vecs[1]  = '{2'b11, 1'b1, 2'b10};
        vecs[2]  = '{2'b01, 1'b1, 2'b01};
        vecs[3]  = '{2'b10, 1'b1, 2'b10};
        vecs[4]  = '{2'b11, 1'b0, 2'b00};
        vecs[5]  = '{2'b11, 1'b0, 2'b00};
        vecs[6]  = '{2'b11, 1'b1, 2'b01};
        vecs[7]  = '{2'b10, 1'b1, 2'b10};
        vecs[8]  = '{2'b00, 1'b1, 2'b00};
        vecs[9]  = '{2'b10, 1'b1, 2'b10};
        vecs[10] = '{2'b01, 1'b1, 2'b01};
        vecs[11] = '{2'b01, 1'b1, 2'b01};
        vecs[12] = '{2'b11, 1'b1, 2'b10};
        vecs[13] = '{2'b11, 1'b1, 2'b01};
        vecs[14] = '{2'b10, 1'b1, 2'b10};

        HRESET = 1'b1; HREADY = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_hsize", {29'd0, HSIZE}, 32'd2);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        preload(3, 32'hDEADBEEF);
        preload(4, 32'h1234_5678);
        preload(8, 32'h8888_0008);
        preload(9, 32'h9999_0009);

        // Single read: address phase one cycle after handshake, response three cycles after.
        do_req(0, 1'b0, 32'h0C, 32'h0);
        @(negedge HCLK);
        check("rd_htrans", {30'd0, HTRANS}, 32'd2);
        check("rd_haddr", HADDR, 32'h0C);
        @(negedge HCLK);
        check("rd_rsp_early", {30'd0, rsp_valid}, 32'd0);
        @(negedge HCLK);
        check("rd_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        @(posedge HCLK); #1;

        // Write then read back by requester 1, back to back.
        do_req(1, 1'b1, 32'h40, 32'hA5A5_0001);
        do_req(1, 1'b0, 32'h40, 32'h0);
        @(negedge HCLK);
        check("wr_hwdata", HWDATA, 32'hA5A5_0001);
        check("rd_hwrite", {31'd0, HWRITE}, 32'd0);
        @(negedge HCLK);
        check("wr_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        @(negedge HCLK);
        check("rb_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        check("rb_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
        drain();

        // Grant vector table, starting from a freshly reset pointer.
        do_reset();
        set_req(0, 1'b0, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h24, 32'h0);
        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            HREADY    = vecs[i].hready;
            @(negedge HCLK);
            check($sformatf("vec%0d_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].exp_ready});
            @(posedge HCLK); #1;
        end
        req_valid = '0;
        HREADY    = 1'b1;
        drain();

        // Fairness: both requesters held valid, grants alternate with no idle gaps.
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            check($sformatf("rr%0d_grant", i), {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check($sformatf("rr%0d_htrans", i), {30'd0, HTRANS}, 32'd2);
            @(posedge HCLK); #1;
        end
        req_valid = '0;
        @(negedge HCLK);
        check("rr_last_htrans", {30'd0, HTRANS}, 32'd2);
        drain();

        // Wait states: three low-HREADY cycles in the read's data phase.
        do_req(0, 1'b0, 32'h0C, 32'h0);
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge HCLK);
        s_haddr = HADDR; s_htrans = HTRANS; s_hwdata = HWDATA;
        check("ws_haddr_hold", s_haddr, 32'h0C);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge HCLK);
            check("ws_ready_zero", {30'd0, req_ready}, 32'd0);
            check("ws_rsp_zero", {30'd0, rsp_valid}, 32'd0);
            check("ws_haddr_stable", HADDR, s_haddr);
            check("ws_htrans_stable", {30'd0, HTRANS}, {30'd0, s_htrans});
            check("ws_hwdata_stable", HWDATA, s_hwdata);
        end
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        @(negedge HCLK);
        check("ws_rsp_not_yet", {30'd0, rsp_valid}, 32'd0);
        check("ws_ready_resume", {30'd0, req_ready}, 32'd2);
        @(posedge HCLK); #1;
        req_valid = '0;
        @(negedge HCLK);
        check("ws_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("ws_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        drain();

        // Reset while both pipeline stages hold transfers.
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge HCLK); @(posedge HCLK); #1;
        @(negedge HCLK); @(posedge HCLK); #1;
        HRESET = 1'b1;
        req_valid = '0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("mr_htrans", {30'd0, HTRANS}, 32'd0);
        check("mr_haddr", HADDR, 32'd0);
        check("mr_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(posedge HCLK); #1;
        req_valid = 2'b11;
        @(negedge HCLK);
        check("mr_first_grant", {30'd0, req_ready}, 32'd1);
        @(posedge HCLK); #1;
        req_valid = 2'b10;
        @(negedge HCLK);
        check("mr_second_grant", {30'd0, req_ready}, 32'd2);
        @(posedge HCLK); #1;
        req_valid = '0;
        drain();

        // Idle bus, then an unaligned read that must go out word-aligned.
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("idle_htrans", {30'd0, HTRANS}, 32'd0);
            check("idle_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        @(posedge HCLK); #1;
        do_req(0, 1'b0, 32'h13, 32'h0);
        @(negedge HCLK);
        check("ua_haddr", HADDR, 32'h10);
        check("ua_htrans", {30'd0, HTRANS}, 32'd2);
        drain();

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
